lsu_ctrl: RTL and testbench

Load/store sequencer between the core's execute stage and the data-memory bus. Takes the decoded memory access (load/store flag, `loadCtrl`/`storeCtrl` size codes, ALU-computed address, store data) and runs a request/grant/response handshake with data memory. While the access is in flight it stalls the core. It steers byte lanes, sign- or zero-extends load data, and raises faults for misaligned, illegal-size and timed-out accesses.

---
 rtl/lsu_pkg.sv | 54 +++++
 rtl/lsu_ctrl_if.sv | 33 +++
 rtl/lsu_align.sv | 70 +++++++
 rtl/lsu_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types and encodings for the load/store sequencer.
//               FSM state enum, load/store funct3 codes (matching the main
//               decoder), access-size codes, fault causes and a helper that
//               flags legal load encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } lsu_state_e;

  // Load funct3
  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  // Store funct3[1:0]
  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;

  // Access size, taken from funct3[1:0] for both directions
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // fault_cause codes
  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;
  localparam logic [1:0] FAULT_ILLEGAL  = 2'b11;

  function automatic logic load_legal(input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU: ok = 1'b1;
      default:                             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl_if
// Description : Data-memory bus between the load/store sequencer (master)
//               and data memory (slave).
//               mem_req/mem_we/mem_addr/mem_be/mem_wdata : request channel
//               mem_gnt                                   : request accepted
//               mem_rvalid/mem_rdata                      : read response
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_ctrl_if;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational byte-lane steering for the sequencer.
//               Store side : st_size/st_off/st_data -> st_be, st_wdata
//                            (byte enables and lane-replicated data)
//               Load side  : ld_funct3/ld_off/ld_rdata -> ld_result
//                            (byte/half extraction, sign/zero extension)
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align (
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_result
);
  import lsu_pkg::*;

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Store direction. Data is replicated on every lane so memory can pick
  // whichever lanes the byte enables select.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    case (st_size)
      SIZE_BYTE: begin
        st_be    = 4'b0001 << st_off;
        st_wdata = {4{st_data[7:0]}};
      end
      SIZE_HALF: begin
        st_be    = st_off[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = st_data;
      end
    endcase
  end

  // Load direction
  always_comb begin
    w_byte = ld_rdata[7:0];
    case (ld_off)
      2'd0:    w_byte = ld_rdata[7:0];
      2'd1:    w_byte = ld_rdata[15:8];
      2'd2:    w_byte = ld_rdata[23:16];
      default: w_byte = ld_rdata[31:24];
    endcase
    w_half = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];

    ld_result = ld_rdata;
    case (ld_funct3)
      LD_LB:   ld_result = {{24{w_byte[7]}}, w_byte};
      LD_LH:   ld_result = {{16{w_half[15]}}, w_half};
      LD_LBU:  ld_result = {24'h0, w_byte};
      LD_LHU:  ld_result = {16'h0, w_half};
      default: ld_result = ld_rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl
// Description : Load/store sequencer between execute stage and data memory.
//               Runs a req/gnt/rvalid handshake, stalls the core while an
//               access is in flight, and faults on misaligned, illegal-size
//               or timed-out accesses.
//   clk, reset           : clock, asynchronous active-high reset
//   load_en, store_en    : access request from execute (load wins if both)
//   load_ctrl/store_ctrl : size codes (funct3)
//   addr, store_data     : effective byte address, rs2 value
//   stall                : hold PC/pipeline inputs
//   done, load_data      : access complete, extended load result
//   fault, fault_cause   : access aborted, 01 misalign/10 timeout/11 size
//   bus                  : data-memory bus (master side)
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_en,
  input  logic        store_en,
  input  logic [2:0]  load_ctrl,
  input  logic [1:0]  store_ctrl,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        fault,
  output logic [1:0]  fault_cause,
  lsu_ctrl_if.master  bus
);
  import lsu_pkg::*;

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e       r_state;
  lsu_state_e       w_next;
  logic [CNT_W-1:0] r_cnt;

  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_wdata;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic [31:0] r_load_data;
  logic [1:0]  r_fault_cause;

  logic        w_access;
  logic        w_we;
  logic [1:0]  w_size;
  logic        w_legal;
  logic        w_misalign;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ld_result;
  logic        w_launch;
  logic        w_capture;
  logic        w_to_err;
  logic [1:0]  w_err_cause;

  // Request decode; a simultaneous load and store is handled as a load
  always_comb begin
    w_access   = load_en | store_en;
    w_we       = store_en & ~load_en;
    w_size     = load_en ? load_ctrl[1:0] : store_ctrl;
    w_legal    = load_en ? load_legal(load_ctrl)
                         : (store_ctrl inside {ST_SB, ST_SH, ST_SW});
    w_misalign = ((w_size == SIZE_HALF) && addr[0]) ||
                 ((w_size == SIZE_WORD) && (addr[1:0] != 2'b00));
  end

  // Store lanes use the live request; load extraction uses the latched
  // funct3/offset because the response arrives after the request cycle.
  lsu_align u_align (
    .st_size   (w_size),
    .st_off    (addr[1:0]),
    .st_data   (store_data),
    .st_be     (w_be),
    .st_wdata  (w_wdata),
    .ld_funct3 (r_funct3),
    .ld_off    (r_off),
    .ld_rdata  (bus.mem_rdata),
    .ld_result (w_ld_result)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_launch    = 1'b0;
    w_capture   = 1'b0;
    w_to_err    = 1'b0;
    w_err_cause = FAULT_NONE;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          if (!w_legal) begin
            w_next      = S_ERR;
            w_to_err    = 1'b1;
            w_err_cause = FAULT_ILLEGAL;
          end else if (w_misalign) begin
            w_next      = S_ERR;
            w_to_err    = 1'b1;
            w_err_cause = FAULT_MISALIGN;
          end else begin
            w_next   = S_REQ;
            w_launch = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (bus.mem_gnt) begin
          if (r_mem_we) begin
            w_next = S_DONE;
          end else if (bus.mem_rvalid) begin
            w_next    = S_DONE;
            w_capture = 1'b1;
          end else begin
            w_next = S_WAIT;
          end
        end else if (r_cnt == CNT_LAST) begin
          w_next      = S_ERR;
          w_to_err    = 1'b1;
          w_err_cause = FAULT_TIMEOUT;
        end
      end
      S_WAIT: begin
        if (bus.mem_rvalid) begin
          w_next    = S_DONE;
          w_capture = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_next      = S_ERR;
          w_to_err    = 1'b1;
          w_err_cause = FAULT_TIMEOUT;
        end
      end
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath registers. mem_req is registered from the next state so it is
  // high exactly while the FSM sits in REQ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= 32'h0;
      r_mem_be      <= 4'h0;
      r_mem_wdata   <= 32'h0;
      r_funct3      <= 3'h0;
      r_off         <= 2'h0;
      r_cnt         <= '0;
      r_load_data   <= 32'h0;
      r_fault_cause <= 2'h0;
    end else begin
      r_mem_req <= (w_next == S_REQ);
      if (w_launch) begin
        r_mem_we    <= w_we;
        r_mem_addr  <= {addr[31:2], 2'b00};
        r_mem_be    <= w_be;
        r_mem_wdata <= w_wdata;
        r_funct3    <= load_en ? load_ctrl : {1'b0, store_ctrl};
        r_off       <= addr[1:0];
        r_cnt       <= '0;
      end else if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_capture) r_load_data   <= w_ld_result;
      if (w_to_err)  r_fault_cause <= w_err_cause;
    end
  end

  assign stall = w_access &&
                 ((r_state == S_IDLE) || (r_state == S_REQ) || (r_state == S_WAIT));
  assign done        = (r_state == S_DONE);
  assign fault       = (r_state == S_ERR);
  assign load_data   = r_load_data;
  assign fault_cause = r_fault_cause;

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_be    = r_mem_be;
  assign bus.mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_ctrl
// Description : Directed self-checking bench for lsu_ctrl (TIMEOUT_CYCLES=4)
//               with a scoreboard of expected completions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_en, store_en;
  logic [2:0]  load_ctrl;
  logic [1:0]  store_ctrl;
  logic [31:0] addr, store_data;
  logic        stall, done, fault;
  logic [31:0] load_data;
  logic [1:0]  fault_cause;

  lsu_ctrl_if bus ();

  lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_en     (load_en),
    .store_en    (store_en),
    .load_ctrl   (load_ctrl),
    .store_ctrl  (store_ctrl),
    .addr        (addr),
    .store_data  (store_data),
    .stall       (stall),
    .done        (done),
    .load_data   (load_data),
    .fault       (fault),
    .fault_cause (fault_cause),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_fault;
    logic [1:0]  cause;
    bit          chk_data;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    load_en = 1'b0; store_en = 1'b0; load_ctrl = 3'b000; store_ctrl = 2'b00;
    addr = 32'h0; store_data = 32'h0;
  endtask

  // One access from the IDLE cycle (cycle 1) to completion. The bench acts
  // as memory: grants after gnt_wait request cycles, returns read data in
  // the grant cycle (rv_same) or the cycle after.
  task automatic run_access(
    input string       tag,
    input bit          ld, input bit st,
    input logic [2:0]  lc, input logic [1:0] sc,
    input logic [31:0] a,  input logic [31:0] sd,
    input int          gnt_wait, input bit rv_same, input logic [31:0] rd,
    input logic [3:0]  exp_be, input logic [31:0] exp_wdata,
    input int          exp_reqs, input int exp_cycle,
    input bit          exp_fault, input logic [1:0] exp_cause,
    input bit          chk_data, input logic [31:0] exp_data);
    int   cyc;
    int   reqs;
    bit   got;
    bit   rv_pending;
    bit   exp_we;
    exp_t e;
    exp_we = st && !ld;
    load_en = ld; store_en = st; load_ctrl = lc; store_ctrl = sc;
    addr = a; store_data = sd;
    sb.push_back('{exp_fault, exp_cause, chk_data, exp_data});
    #1;
    chk({tag, "_stall_idle"}, stall, 1'b1);
    cyc = 1; reqs = 0; got = 1'b0; rv_pending = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      tick();
      cyc++;
      bus.mem_gnt = 1'b0;
      bus.mem_rvalid = 1'b0;
      if (rv_pending) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rd;
        rv_pending     = 1'b0;
      end
      if (done || fault) begin
        got = 1'b1;
        chk({tag, "_cycle"}, cyc, exp_cycle);
        chk({tag, "_stall_end"}, stall, 1'b0);
        chk({tag, "_reqs"}, reqs, exp_reqs);
        if (sb.size() == 0) begin
          chk({tag, "_sb_empty"}, 1, 0);
        end else begin
          e = sb.pop_front();
          chk({tag, "_fault"}, fault, e.is_fault);
          chk({tag, "_done"}, done, !e.is_fault);
          if (e.is_fault) chk({tag, "_cause"}, fault_cause, e.cause);
          else if (e.chk_data) chk({tag, "_load_data"}, load_data, e.data);
        end
      end else if (bus.mem_req) begin
        reqs++;
        chk({tag, "_mem_addr"}, bus.mem_addr, {a[31:2], 2'b00});
        chk({tag, "_mem_be"}, bus.mem_be, exp_be);
        chk({tag, "_mem_we"}, bus.mem_we, exp_we);
        if (exp_we) chk({tag, "_mem_wdata"}, bus.mem_wdata, exp_wdata);
        if (reqs > gnt_wait) begin
          bus.mem_gnt = 1'b1;
          if (!exp_we) begin
            if (rv_same) begin
              bus.mem_rvalid = 1'b1;
              bus.mem_rdata  = rd;
            end else begin
              rv_pending = 1'b1;
            end
          end
        end
      end
    end
    chk({tag, "_completed"}, got, 1'b1);
    idle_inputs();
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_stall", stall, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_be", bus.mem_be, 4'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_fault_cause", fault_cause, 2'b00);

    //          tag     ld st lc      sc     addr          sdata         gw rvs rdata         be       wdata         rq cy flt cause chk data
    run_access("sb",    0, 1, 3'b000, 2'b00, 32'h0000_0103, 32'hAABB_CCDD, 0, 0, 32'h0,         4'b1000, 32'hDDDD_DDDD, 1, 3, 0, 2'b00, 0, 32'h0);
    run_access("lb",    1, 0, 3'b000, 2'b00, 32'h0000_0201, 32'h0,         0, 0, 32'h0000_80FF, 4'b0010, 32'h0,         1, 4, 0, 2'b00, 1, 32'hFFFF_FF80);
    run_access("lbu",   1, 0, 3'b100, 2'b00, 32'h0000_0201, 32'h0,         0, 0, 32'h0000_80FF, 4'b0010, 32'h0,         1, 4, 0, 2'b00, 1, 32'h0000_0080);
    run_access("lh",    1, 0, 3'b001, 2'b00, 32'h0000_0302, 32'h0,         0, 1, 32'h8001_1234, 4'b1100, 32'h0,         1, 3, 0, 2'b00, 1, 32'hFFFF_8001);
    run_access("lhu_w", 1, 0, 3'b101, 2'b00, 32'h0000_0300, 32'h0,         2, 0, 32'h8001_1234, 4'b0011, 32'h0,         3, 6, 0, 2'b00, 1, 32'h0000_1234);
    run_access("lw",    1, 0, 3'b010, 2'b00, 32'h0000_0400, 32'h0,         0, 1, 32'h1234_5678, 4'b1111, 32'h0,         1, 3, 0, 2'b00, 1, 32'h1234_5678);
    run_access("lb3",   1, 0, 3'b000, 2'b00, 32'h0000_0503, 32'h0,         1, 1, 32'h7F00_0000, 4'b1000, 32'h0,         2, 4, 0, 2'b00, 1, 32'h0000_007F);
    run_access("sh",    0, 1, 3'b000, 2'b01, 32'h0000_0102, 32'h0000_BEEF, 0, 0, 32'h0,         4'b1100, 32'hBEEF_BEEF, 1, 3, 0, 2'b00, 0, 32'h0);
    run_access("sw",    0, 1, 3'b000, 2'b10, 32'h0000_0010, 32'hCAFE_F00D, 1, 0, 32'h0,         4'b1111, 32'hCAFE_F00D, 2, 4, 0, 2'b00, 0, 32'h0);
    run_access("ld_st", 1, 1, 3'b010, 2'b10, 32'h0000_0020, 32'h5555_AAAA, 0, 1, 32'hDEAD_BEEF, 4'b1111, 32'h0,         1, 3, 0, 2'b00, 1, 32'hDEAD_BEEF);
    run_access("lw_mis",1, 0, 3'b010, 2'b00, 32'h0000_0006, 32'h0,         0, 0, 32'h0,         4'b0000, 32'h0,         0, 2, 1, 2'b01, 0, 32'h0);
    run_access("ld_011",1, 0, 3'b011, 2'b00, 32'h0000_0000, 32'h0,         0, 0, 32'h0,         4'b0000, 32'h0,         0, 2, 1, 2'b11, 0, 32'h0);
    run_access("st_11", 0, 1, 3'b000, 2'b11, 32'h0000_0000, 32'h0,         0, 0, 32'h0,         4'b0000, 32'h0,         0, 2, 1, 2'b11, 0, 32'h0);
    run_access("sh_mis",0, 1, 3'b000, 2'b01, 32'h0000_0101, 32'h0,         0, 0, 32'h0,         4'b0000, 32'h0,         0, 2, 1, 2'b01, 0, 32'h0);
    run_access("sw_to", 0, 1, 3'b000, 2'b10, 32'h0000_0040, 32'h0102_0304, 1000, 0, 32'h0,      4'b1111, 32'h0102_0304, 4, 6, 1, 2'b10, 0, 32'h0);

    // Late response after the timeout must not complete anything
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hFFFF_FFFF;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("late_rv_done", done, 1'b0);
    chk("late_rv_fault", fault, 1'b0);
    tick();
    chk("late_rv_done2", done, 1'b0);

    // Reset while waiting for read data
    load_en = 1'b1; load_ctrl = 3'b010; addr = 32'h0000_0080;
    tick();                                   // REQ
    chk("rstw_req", bus.mem_req, 1'b1);
    bus.mem_gnt = 1'b1;
    tick();                                   // WAIT
    bus.mem_gnt = 1'b0;
    chk("rstw_stall_wait", stall, 1'b1);
    chk("rstw_req_wait", bus.mem_req, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("rstw_req_rst", bus.mem_req, 1'b0);
    chk("rstw_done_rst", done, 1'b0);
    idle_inputs();
    #1;
    chk("rstw_stall_rst", stall, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hA5A5_A5A5;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("rstw_stale_done", done, 1'b0);
    chk("rstw_stale_req", bus.mem_req, 1'b0);
    tick();
    chk("rstw_stale_done2", done, 1'b0);
    chk("rstw_load_data", load_data, 32'h0);
    chk("rstw_mem_addr", bus.mem_addr, 32'h0);

    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
